// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller.
//   state_e          : request/service handshake states
//   *_OFF            : register byte offsets from the window base
//   ACTIVE_VALID_BIT : "in service" flag position in the ACTIVE register
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam logic [3:0] PEND_OFF   = 4'd0;
  localparam logic [3:0] MASK_OFF   = 4'd4;
  localparam logic [3:0] ACTIVE_OFF = 4'd8;
  localparam logic [3:0] EOI_OFF    = 4'd12;

  localparam int ACTIVE_VALID_BIT = 31;

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Lowest-index-wins priority encoder.
//   vec_i : request vector (bit 0 = highest priority)
//   idx_o : index of the lowest set bit, 0 when none set
//   any_o : at least one bit of vec_i is set
module priority_encoder #(
  parameter int N = 4
) (
  input  logic [N-1:0] vec_i,
  output logic [2:0]   idx_o,
  output logic         any_o
);

  // Scan from the top down so the last assignment is the lowest set bit.
  always_comb begin
    idx_o = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 3'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped interrupt controller.
//   clock, reset (async, active-low)
//   irq_src            : level request lines, bit 0 = cycle timer
//   address/data       : processor bus, MemRead/MemWrite strobes
//   InterruptTaken     : processor has vectored to the handler
//   rdata, CtrlAddress : register read data and window-hit flag
//   InterruptReq/Cause : request to the processor and selected source
// Register window: PENDING (W1C), MASK (RW), ACTIVE (RO), EOI (WO).
module interrupt_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC   = 4,
  parameter logic [31:0] BASE_ADDR = 32'hffff0080
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [31:0]        address,
  input  logic [31:0]        data,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               InterruptTaken,
  output logic [31:0]        rdata,
  output logic               CtrlAddress,
  output logic               InterruptReq,
  output logic [2:0]         InterruptCause
);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [2:0]         cause_q, cause_d;
  logic               active_q, active_d;
  logic               req_q, req_d;

  logic [31:0]        off_w;
  logic [3:0]         word_off;
  logic               wr_pend, wr_mask, wr_eoi;
  logic [NUM_SRC-1:0] rise, wclr, pend_raw, cause_bit;
  logic [2:0]         win_idx;
  logic               win_any;
  logic               keep_req;
  logic               unused_ok;

  // Subtraction wraps addresses below the base to large values, so one
  // unsigned compare covers both ends of the window.
  assign off_w       = address - BASE_ADDR;
  assign CtrlAddress = (off_w <= 32'd12);
  assign word_off    = {off_w[3:2], 2'b00};

  assign wr_pend = MemWrite && CtrlAddress && (word_off == PEND_OFF);
  assign wr_mask = MemWrite && CtrlAddress && (word_off == MASK_OFF);
  assign wr_eoi  = MemWrite && CtrlAddress && (word_off == EOI_OFF);

  assign rise      = irq_src & ~src_q;
  assign wclr      = wr_pend ? data[NUM_SRC-1:0] : '0;
  // Edge is OR-ed in last so a same-cycle set beats a software clear.
  assign pend_raw  = (pending_q & ~wclr) | rise;
  assign mask_d    = wr_mask ? data[NUM_SRC-1:0] : mask_q;
  assign cause_bit = NUM_SRC'(1) << cause_q;

  // Looks at next-cycle pending/mask so a software mask or clear in REQ
  // drops the request on the following cycle.
  assign keep_req = |(pend_raw & mask_d & cause_bit);

  priority_encoder #(.N(NUM_SRC)) u_prio (
    .vec_i (pending_q & mask_q),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    active_d  = active_q;
    pending_d = pend_raw;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = REQ;
          cause_d = win_idx;
        end
      end
      REQ: begin
        if (InterruptTaken) begin
          state_d   = SERVICE;
          active_d  = 1'b1;
          pending_d = (pending_q & ~wclr & ~cause_bit) | rise;
        end else if (!keep_req) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (wr_eoi) begin
          state_d  = IDLE;
          active_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_d = (state_d == REQ);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      cause_q   <= 3'd0;
      active_q  <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= irq_src;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cause_q   <= cause_d;
      active_q  <= active_d;
      req_q     <= req_d;
    end
  end

  assign InterruptReq   = req_q;
  assign InterruptCause = cause_q;

  always_comb begin
    rdata = '0;
    if (CtrlAddress) begin
      case (word_off)
        PEND_OFF: rdata[NUM_SRC-1:0] = pending_q;
        MASK_OFF: rdata[NUM_SRC-1:0] = mask_q;
        ACTIVE_OFF: begin
          if (active_q) begin
            rdata[ACTIVE_VALID_BIT] = 1'b1;
            rdata[2:0]              = cause_q;
          end
        end
        default: rdata = '0;
      endcase
    end
  end

  // Reads have no side effects and upper data bits are don't-care.
  assign unused_ok = ^{MemRead, data[31:NUM_SRC]};

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  localparam logic [31:0] B  = 32'hffff0080;
  localparam logic [31:0] AP = B;
  localparam logic [31:0] AM = B + 32'd4;
  localparam logic [31:0] AA = B + 32'd8;
  localparam logic [31:0] AE = B + 32'd12;
  localparam logic [31:0] AX = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  irq_src;
  logic [31:0] address;
  logic [31:0] data;
  logic        MemRead;
  logic        MemWrite;
  logic        InterruptTaken;
  logic [31:0] rdata;
  logic        CtrlAddress;
  logic        InterruptReq;
  logic [2:0]  InterruptCause;

  interrupt_controller #(.NUM_SRC(4), .BASE_ADDR(B)) dut (
    .clock          (clock),
    .reset          (reset),
    .irq_src        (irq_src),
    .address        (address),
    .data           (data),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .InterruptTaken (InterruptTaken),
    .rdata          (rdata),
    .CtrlAddress    (CtrlAddress),
    .InterruptReq   (InterruptReq),
    .InterruptCause (InterruptCause)
  );

  always #10 clock = ~clock;

  typedef struct {
    string       name;
    logic [3:0]  src;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic        tk;
    logic [31:0] rd;
    logic        req;
    logic [2:0]  cause;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        ctrl;
    logic        req;
    logic [2:0]  cause;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t v(string name, logic [3:0] src, logic [31:0] addr,
                             logic we, logic [31:0] wd, logic tk,
                             logic [31:0] rd, logic req, logic [2:0] cause);
    vec_t r;
    r.name = name; r.src = src; r.addr = addr; r.we = we; r.wd = wd;
    r.tk = tk; r.rd = rd; r.req = req; r.cause = cause;
    return r;
  endfunction

  function automatic logic in_window(logic [31:0] a);
    return (a >= B) && (a <= B + 32'd12);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs(string nm, logic [31:0] rd, logic ctrl, logic req, logic [2:0] cause);
    chk({nm, ".rdata"}, rdata, rd);
    chk({nm, ".ctrl"}, {31'd0, CtrlAddress}, {31'd0, ctrl});
    chk({nm, ".req"}, {31'd0, InterruptReq}, {31'd0, req});
    if (req) chk({nm, ".cause"}, {29'd0, InterruptCause}, {29'd0, cause});
  endtask

  initial begin
    exp_t e;

    // Vectors: inputs driven after a falling edge; expectations describe
    // outputs before the next rising edge (i.e. effect of earlier vectors).
    vecs.push_back(v("rst_edge_pend", 4'b0001, AP, 0, 0, 0, 32'h1, 0, 0));
    vecs.push_back(v("mask_wr1",      4'b0001, AM, 1, 32'h1, 0, 32'h0, 0, 0));
    vecs.push_back(v("req_wait",      4'b0001, AX, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(v("req_src0",      4'b0001, AX, 0, 0, 1, 32'h0, 1, 0));
    vecs.push_back(v("active_src0",   4'b0001, AA, 0, 0, 0, 32'h8000_0000, 0, 0));
    vecs.push_back(v("eoi0",          4'b0001, AE, 1, 32'h0, 0, 32'h0, 0, 0));
    vecs.push_back(v("level_once",    4'b0000, AP, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(v("mask_wrf",      4'b0000, AM, 1, 32'hffff_ffff, 0, 32'h1, 0, 0));
    vecs.push_back(v("edge_2_1",      4'b0110, AX, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(v("pend_6",        4'b0110, AP, 0, 0, 0, 32'h6, 0, 0));
    vecs.push_back(v("req_src1",      4'b0110, AX, 0, 0, 1, 32'h0, 1, 1));
    vecs.push_back(v("active_src1",   4'b0110, AA, 0, 0, 0, 32'h8000_0001, 0, 0));
    vecs.push_back(v("pend_after_tk", 4'b0110, AP, 0, 0, 0, 32'h4, 0, 0));
    vecs.push_back(v("eoi1",          4'b0110, AE, 1, 32'h0, 0, 32'h0, 0, 0));
    vecs.push_back(v("eoi1_wait",     4'b0110, AX, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(v("req_src2",      4'b0110, AX, 0, 0, 0, 32'h0, 1, 2));
    vecs.push_back(v("mask0_in_req",  4'b0110, AM, 1, 32'h0, 0, 32'hf, 1, 2));
    vecs.push_back(v("req_dropped",   4'b0110, AX, 0, 0, 1, 32'h0, 0, 0));
    vecs.push_back(v("pend_kept",     4'b0110, AP, 0, 0, 0, 32'h4, 0, 0));
    vecs.push_back(v("src1_low",      4'b0100, AX, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(v("w1c_vs_edge",   4'b0110, AP, 1, 32'h2, 0, 32'h4, 0, 0));
    vecs.push_back(v("set_wins",      4'b0110, AP, 0, 0, 0, 32'h6, 0, 0));
    vecs.push_back(v("mask_wrf2",     4'b0110, AM, 1, 32'hf, 0, 32'h0, 0, 0));
    vecs.push_back(v("req_wait2",     4'b0110, AX, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(v("req_src1b",     4'b0110, AX, 0, 0, 1, 32'h0, 1, 1));
    vecs.push_back(v("svc_edge0",     4'b0111, AX, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(v("svc_pend5",     4'b0111, AP, 0, 0, 0, 32'h5, 0, 0));
    vecs.push_back(v("svc_hold",      4'b0111, AX, 0, 0, 1, 32'h0, 0, 0));
    vecs.push_back(v("eoi2",          4'b0111, AE, 1, 32'h0, 0, 32'h0, 0, 0));
    vecs.push_back(v("eoi2_wait",     4'b0111, AX, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(v("req_src0b",     4'b0111, AX, 0, 0, 1, 32'h0, 1, 0));
    vecs.push_back(v("active_src0b",  4'b0111, AA, 0, 0, 0, 32'h8000_0000, 0, 0));

    reset = 1'b0; irq_src = 4'b0001; address = AP; data = '0;
    MemRead = 1'b0; MemWrite = 1'b0; InterruptTaken = 1'b0;
    #1;
    chk_outputs("rst_pend", 32'h0, 1'b1, 1'b0, 3'd0);
    chk("rst_cause", {29'd0, InterruptCause}, 32'd0);
    address = AM; #1; chk_outputs("rst_mask", 32'h0, 1'b1, 1'b0, 3'd0);
    address = AA; #1; chk_outputs("rst_active", 32'h0, 1'b1, 1'b0, 3'd0);
    address = AE; #1; chk_outputs("eoi_read0", 32'h0, 1'b1, 1'b0, 3'd0);
    address = B - 32'd4;  #1; chk_outputs("below_win", 32'h0, 1'b0, 1'b0, 3'd0);
    address = B + 32'd16; #1; chk_outputs("above_win", 32'h0, 1'b0, 1'b0, 3'd0);

    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);

    foreach (vecs[i]) begin
      @(negedge clock);
      irq_src        = vecs[i].src;
      address        = vecs[i].addr;
      MemWrite       = vecs[i].we;
      MemRead        = ~vecs[i].we;
      data           = vecs[i].wd;
      InterruptTaken = vecs[i].tk;
      e.name  = vecs[i].name;
      e.rd    = vecs[i].rd;
      e.ctrl  = in_window(vecs[i].addr);
      e.req   = vecs[i].req;
      e.cause = vecs[i].cause;
      sb.push_back(e);
      #2;
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL scoreboard_empty at %s", vecs[i].name);
      end else begin
        e = sb.pop_front();
        chk_outputs(e.name, e.rd, e.ctrl, e.req, e.cause);
      end
    end

    // Now in SERVICE: reset asserted between clock edges must clear at once.
    MemWrite = 1'b0; InterruptTaken = 1'b0; address = AA;
    #4;
    reset = 1'b0;
    #1; chk_outputs("async_rst_active", 32'h0, 1'b1, 1'b0, 3'd0);
    chk("async_rst_cause", {29'd0, InterruptCause}, 32'd0);
    address = AP; #1; chk_outputs("async_rst_pend", 32'h0, 1'b1, 1'b0, 3'd0);
    address = AM; #1; chk_outputs("async_rst_mask", 32'h0, 1'b1, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Memory-mapped interrupt controller between the interrupt sources (the cycle timer on source 0, plus other peripherals) and the processor's single interrupt input. It edge-detects and latches requests, applies a software mask, selects the highest-priority request, and holds it through a request/taken/end-of-interrupt handshake. Acknowledging a source at its own device (for example the timer's acknowledge address) is unrelated to this block's end-of-interrupt (EOI) step.

## Interface
- NUM_SRC, 4: number of interrupt sources, 2..8.
- BASE_ADDR, 32'hffff0080: word-aligned base of the four-register window.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted); clears all state immediately.
- irq_src  in  NUM_SRC  level request lines; bit 0 = TimerInterrupt.
- address  in  32  processor data address.
- data  in  32  processor write data.
- MemRead  in  1  processor load strobe.
- MemWrite  in  1  processor store strobe.
- InterruptTaken  in  1  one-cycle pulse: the processor has vectored to the handler.
- rdata  out  32  read data; 0 when no register hit.
- CtrlAddress  out  1  address is within BASE_ADDR..BASE_ADDR+12.
- InterruptReq  out  1  interrupt request to the processor.
- InterruptCause  out  3  index of the selected source; valid while InterruptReq=1.

## Operation
- Registers:
  - PENDING (+0): read returns pending in bits [NUM_SRC-1:0]; a write clears each bit where data is 1 (write-1-to-clear).
  - MASK (+4): read/write, bits [NUM_SRC-1:0]; 1 = enabled.
  - ACTIVE (+8): read-only; bit 31 = in service, bits [2:0] = serviced index.
  - EOI (+12): any write ends service; reads return 0.
- Bits of data and rdata above NUM_SRC are ignored on write and read as 0.
- Edge detect: a registered copy of irq_src is kept. A 0→1 transition sets the pending bit, so a held level raises only one request.
- Set/clear collision: a pending bit that is set by an edge and cleared by a PENDING write in the same cycle stays set (set wins).
- Eligible set = pending & mask. The winner is the lowest-index eligible bit.
- State machine:
  - IDLE: if eligible ≠ 0, go to REQ and latch the winner index into cause.
  - REQ: InterruptReq=1.
    - If InterruptTaken=1: go to SERVICE, clear pending[cause], and set ACTIVE.
    - Otherwise, if pending[cause] & mask[cause] has dropped (masked or cleared by software): go back to IDLE and drop InterruptReq.
    - A newly eligible higher-priority source does not preempt REQ.
  - SERVICE: InterruptReq=0. Edges continue to set pending bits. An EOI write clears ACTIVE and returns to IDLE.
- InterruptTaken seen in IDLE or SERVICE is ignored.
- An EOI write seen in IDLE or REQ is ignored.
- A write only takes effect when MemWrite=1 and the word address hits. Writes while MemRead=1 still apply.

## Timing
- Reset values: pending=0, MASK=0, ACTIVE=0, edge register=0, state=IDLE, InterruptReq=0, InterruptCause=0.
- A source that is already high when reset releases counts as an edge on the first clock.
- Pending latency: the edge is sampled at clock N, so pending is visible from cycle N+1.
- Request latency: InterruptReq is registered and rises one cycle after eligible ≠ 0 in IDLE. The edge-to-InterruptReq latency is 2 cycles.
- rdata and CtrlAddress are combinational from address and current register state.
- InterruptReq falls the cycle after InterruptTaken.
- After EOI, a still-eligible source raises InterruptReq again two cycles later: EOI→IDLE takes one cycle, IDLE→REQ takes one.
- Reset asserted mid-operation (in REQ or SERVICE) forces all outputs to their reset values asynchronously. No handshake is completed.

## Structure
- Shared package irq_pkg holds:
  - the state enum (IDLE, REQ, SERVICE);
  - register offsets (PEND_OFF=0, MASK_OFF=4, ACTIVE_OFF=8, EOI_OFF=12);
  - the ACTIVE valid-bit position (31).
- Sub-module priority_encoder: NUM_SRC-bit vector in, 3-bit lowest-set index and an any-set flag out. Purely combinational; reused by the top level.
- Top level holds the edge register, pending/mask registers, state machine, decode and read mux.

## Test plan
- Reset low with irq_src=4'b0001 held, then release, with MASK=0: PENDING reads 1 and InterruptReq stays 0. Write MASK=1: InterruptReq=1 two cycles later and InterruptCause=0.
- Edges on sources 2 and 1 in the same cycle, MASK=4'hf:
  - InterruptCause=1; pulse InterruptTaken; ACTIVE reads 32'h80000001 and PENDING reads 4'b0100.
  - EOI write, then InterruptCause=2 with the request returning two cycles later.
- In REQ, write MASK=0: InterruptReq drops the next cycle, state returns to IDLE, and pending[cause] stays 1.
- A PENDING write of 4'b0010 in the same cycle as a new source-1 edge: bit 1 remains set.
- In SERVICE, a new source-0 edge: InterruptReq stays 0 until the EOI write, then reasserts 2 cycles later with cause 0.
- Assert reset while in SERVICE: InterruptReq, ACTIVE, PENDING and MASK read 0 immediately, asynchronously with no clock edge.
